// File: rtl/fb_arbiter_pkg.sv
// rtl/fb_arbiter_pkg.sv - shared types and constants for the framebuffer bus arbiter
package fb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int PORT_VGA = 0;
    localparam int PORT_WR  = 1;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = DAT_W / 8;

    function automatic logic [1:0] grant_of(arb_state_t s);
        case (s)
            OWN0:    return 2'b01;
            OWN1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/fb_wshb_mux.sv
// rtl/fb_wshb_mux.sv - combinational Wishbone request mux / response demux keyed by owner state
module fb_wshb_mux
    import fb_arbiter_pkg::*;
(
    input  arb_state_t       state,
    input  logic             s0_cyc,
    input  logic             s0_stb,
    input  logic             s0_we,
    input  logic [ADR_W-1:0] s0_adr,
    input  logic [DAT_W-1:0] s0_dat_ms,
    input  logic [SEL_W-1:0] s0_sel,
    input  logic [2:0]       s0_cti,
    input  logic [1:0]       s0_bte,
    output logic             s0_ack,
    output logic             s0_err,
    output logic [DAT_W-1:0] s0_dat_sm,
    input  logic             s1_cyc,
    input  logic             s1_stb,
    input  logic             s1_we,
    input  logic [ADR_W-1:0] s1_adr,
    input  logic [DAT_W-1:0] s1_dat_ms,
    input  logic [SEL_W-1:0] s1_sel,
    input  logic [2:0]       s1_cti,
    input  logic [1:0]       s1_bte,
    output logic             s1_ack,
    output logic             s1_err,
    output logic [DAT_W-1:0] s1_dat_sm,
    output logic             m_cyc,
    output logic             m_stb,
    output logic             m_we,
    output logic [ADR_W-1:0] m_adr,
    output logic [DAT_W-1:0] m_dat_ms,
    output logic [SEL_W-1:0] m_sel,
    output logic [2:0]       m_cti,
    output logic [1:0]       m_bte,
    input  logic             m_ack,
    input  logic             m_err,
    input  logic [DAT_W-1:0] m_dat_sm
);

    // Non-owners see a silent bus: zero responses, so a waiting master never sees stray acks.
    always_comb begin
        m_cyc     = 1'b0;
        m_stb     = 1'b0;
        m_we      = 1'b0;
        m_adr     = '0;
        m_dat_ms  = '0;
        m_sel     = '0;
        m_cti     = '0;
        m_bte     = '0;
        s0_ack    = 1'b0;
        s0_err    = 1'b0;
        s0_dat_sm = '0;
        s1_ack    = 1'b0;
        s1_err    = 1'b0;
        s1_dat_sm = '0;
        case (state)
            OWN0: begin
                m_cyc     = s0_cyc;
                m_stb     = s0_stb;
                m_we      = s0_we;
                m_adr     = s0_adr;
                m_dat_ms  = s0_dat_ms;
                m_sel     = s0_sel;
                m_cti     = s0_cti;
                m_bte     = s0_bte;
                s0_ack    = m_ack;
                s0_err    = m_err;
                s0_dat_sm = m_dat_sm;
            end
            OWN1: begin
                m_cyc     = s1_cyc;
                m_stb     = s1_stb;
                m_we      = s1_we;
                m_adr     = s1_adr;
                m_dat_ms  = s1_dat_ms;
                m_sel     = s1_sel;
                m_cti     = s1_cti;
                m_bte     = s1_bte;
                s1_ack    = m_ack;
                s1_err    = m_err;
                s1_dat_sm = m_dat_sm;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - two-master round-robin Wishbone arbiter for the SDRAM framebuffer bus
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int INIT_LAST = 1
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic             wshb_ifs_0_cyc,
    input  logic             wshb_ifs_0_stb,
    input  logic             wshb_ifs_0_we,
    input  logic [ADR_W-1:0] wshb_ifs_0_adr,
    input  logic [DAT_W-1:0] wshb_ifs_0_dat_ms,
    input  logic [SEL_W-1:0] wshb_ifs_0_sel,
    input  logic [2:0]       wshb_ifs_0_cti,
    input  logic [1:0]       wshb_ifs_0_bte,
    output logic             wshb_ifs_0_ack,
    output logic             wshb_ifs_0_err,
    output logic [DAT_W-1:0] wshb_ifs_0_dat_sm,
    input  logic             wshb_ifs_1_cyc,
    input  logic             wshb_ifs_1_stb,
    input  logic             wshb_ifs_1_we,
    input  logic [ADR_W-1:0] wshb_ifs_1_adr,
    input  logic [DAT_W-1:0] wshb_ifs_1_dat_ms,
    input  logic [SEL_W-1:0] wshb_ifs_1_sel,
    input  logic [2:0]       wshb_ifs_1_cti,
    input  logic [1:0]       wshb_ifs_1_bte,
    output logic             wshb_ifs_1_ack,
    output logic             wshb_ifs_1_err,
    output logic [DAT_W-1:0] wshb_ifs_1_dat_sm,
    output logic             wshb_ifm_cyc,
    output logic             wshb_ifm_stb,
    output logic             wshb_ifm_we,
    output logic [ADR_W-1:0] wshb_ifm_adr,
    output logic [DAT_W-1:0] wshb_ifm_dat_ms,
    output logic [SEL_W-1:0] wshb_ifm_sel,
    output logic [2:0]       wshb_ifm_cti,
    output logic [1:0]       wshb_ifm_bte,
    input  logic             wshb_ifm_ack,
    input  logic             wshb_ifm_err,
    input  logic [DAT_W-1:0] wshb_ifm_dat_sm,
    output logic [1:0]       GRANT
);

    if (N_PORTS != 2) begin : g_bad_ports
        $error("fb_arbiter supports exactly two ports");
    end

    arb_state_t state_q, state_d;
    logic       last_q, last_d;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= IDLE;
            last_q  <= 1'(INIT_LAST);
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Ownership lasts from cyc rise to cyc fall; a waiting port takes over without an idle cycle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (wshb_ifs_0_cyc && wshb_ifs_1_cyc) begin
                    state_d = (last_q == 1'(PORT_WR)) ? OWN0 : OWN1;
                end else if (wshb_ifs_0_cyc) begin
                    state_d = OWN0;
                end else if (wshb_ifs_1_cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!wshb_ifs_0_cyc) begin
                    last_d  = 1'(PORT_VGA);
                    state_d = wshb_ifs_1_cyc ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!wshb_ifs_1_cyc) begin
                    last_d  = 1'(PORT_WR);
                    state_d = wshb_ifs_0_cyc ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign GRANT = grant_of(state_q);

    fb_wshb_mux u_mux (
        .state     (state_q),
        .s0_cyc    (wshb_ifs_0_cyc),
        .s0_stb    (wshb_ifs_0_stb),
        .s0_we     (wshb_ifs_0_we),
        .s0_adr    (wshb_ifs_0_adr),
        .s0_dat_ms (wshb_ifs_0_dat_ms),
        .s0_sel    (wshb_ifs_0_sel),
        .s0_cti    (wshb_ifs_0_cti),
        .s0_bte    (wshb_ifs_0_bte),
        .s0_ack    (wshb_ifs_0_ack),
        .s0_err    (wshb_ifs_0_err),
        .s0_dat_sm (wshb_ifs_0_dat_sm),
        .s1_cyc    (wshb_ifs_1_cyc),
        .s1_stb    (wshb_ifs_1_stb),
        .s1_we     (wshb_ifs_1_we),
        .s1_adr    (wshb_ifs_1_adr),
        .s1_dat_ms (wshb_ifs_1_dat_ms),
        .s1_sel    (wshb_ifs_1_sel),
        .s1_cti    (wshb_ifs_1_cti),
        .s1_bte    (wshb_ifs_1_bte),
        .s1_ack    (wshb_ifs_1_ack),
        .s1_err    (wshb_ifs_1_err),
        .s1_dat_sm (wshb_ifs_1_dat_sm),
        .m_cyc     (wshb_ifm_cyc),
        .m_stb     (wshb_ifm_stb),
        .m_we      (wshb_ifm_we),
        .m_adr     (wshb_ifm_adr),
        .m_dat_ms  (wshb_ifm_dat_ms),
        .m_sel     (wshb_ifm_sel),
        .m_cti     (wshb_ifm_cti),
        .m_bte     (wshb_ifm_bte),
        .m_ack     (wshb_ifm_ack),
        .m_err     (wshb_ifm_err),
        .m_dat_sm  (wshb_ifm_dat_sm)
    );

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - self-checking bench for fb_arbiter against a round-robin ownership model
module tb_fb_arbiter;
    import fb_arbiter_pkg::*;

    logic CLK = 1'b0;
    logic NRST;
    always #5 CLK = ~CLK;

    logic             p0_cyc, p0_stb, p0_we, p0_ack, p0_err;
    logic [ADR_W-1:0] p0_adr;
    logic [DAT_W-1:0] p0_dat_ms, p0_dat_sm;
    logic [SEL_W-1:0] p0_sel;
    logic [2:0]       p0_cti;
    logic [1:0]       p0_bte;
    logic             p1_cyc, p1_stb, p1_we, p1_ack, p1_err;
    logic [ADR_W-1:0] p1_adr;
    logic [DAT_W-1:0] p1_dat_ms, p1_dat_sm;
    logic [SEL_W-1:0] p1_sel;
    logic [2:0]       p1_cti;
    logic [1:0]       p1_bte;
    logic             m_cyc, m_stb, m_we, m_ack, m_err;
    logic [ADR_W-1:0] m_adr;
    logic [DAT_W-1:0] m_dat_ms, m_dat_sm;
    logic [SEL_W-1:0] m_sel;
    logic [2:0]       m_cti;
    logic [1:0]       m_bte;
    logic [1:0]       GRANT;

    int checks   = 0;
    int failures = 0;
    int m_owner  = -1;
    int m_last   = 1;

    fb_arbiter #(.N_PORTS(2), .INIT_LAST(1)) dut (
        .CLK(CLK), .NRST(NRST),
        .wshb_ifs_0_cyc(p0_cyc), .wshb_ifs_0_stb(p0_stb), .wshb_ifs_0_we(p0_we),
        .wshb_ifs_0_adr(p0_adr), .wshb_ifs_0_dat_ms(p0_dat_ms), .wshb_ifs_0_sel(p0_sel),
        .wshb_ifs_0_cti(p0_cti), .wshb_ifs_0_bte(p0_bte), .wshb_ifs_0_ack(p0_ack),
        .wshb_ifs_0_err(p0_err), .wshb_ifs_0_dat_sm(p0_dat_sm),
        .wshb_ifs_1_cyc(p1_cyc), .wshb_ifs_1_stb(p1_stb), .wshb_ifs_1_we(p1_we),
        .wshb_ifs_1_adr(p1_adr), .wshb_ifs_1_dat_ms(p1_dat_ms), .wshb_ifs_1_sel(p1_sel),
        .wshb_ifs_1_cti(p1_cti), .wshb_ifs_1_bte(p1_bte), .wshb_ifs_1_ack(p1_ack),
        .wshb_ifs_1_err(p1_err), .wshb_ifs_1_dat_sm(p1_dat_sm),
        .wshb_ifm_cyc(m_cyc), .wshb_ifm_stb(m_stb), .wshb_ifm_we(m_we),
        .wshb_ifm_adr(m_adr), .wshb_ifm_dat_ms(m_dat_ms), .wshb_ifm_sel(m_sel),
        .wshb_ifm_cti(m_cti), .wshb_ifm_bte(m_bte), .wshb_ifm_ack(m_ack),
        .wshb_ifm_err(m_err), .wshb_ifm_dat_sm(m_dat_sm),
        .GRANT(GRANT)
    );

    // Owner keeps the bus while its cyc is high; otherwise requesters are served, ties going away from the last served port.
    function automatic int model_next(logic c0, logic c1);
        int l;
        if (m_owner == 0 && c0) return 0;
        if (m_owner == 1 && c1) return 1;
        l = (m_owner >= 0) ? m_owner : m_last;
        if (c0 && c1) return 1 - l;
        if (c0) return 0;
        if (c1) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] exp_grant();
        if (m_owner == 0) return 2'b01;
        if (m_owner == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
    endtask

    task automatic tick();
        int nxt;
        nxt = model_next(p0_cyc, p1_cyc);
        @(posedge CLK);
        if ((m_owner == 0 && !p0_cyc) || (m_owner == 1 && !p1_cyc)) m_last = m_owner;
        m_owner = nxt;
        #1;
    endtask

    task automatic idle_inputs();
        p0_cyc = 0; p0_stb = 0; p0_we = 0; p0_adr = '0; p0_dat_ms = '0; p0_sel = '0; p0_cti = '0; p0_bte = '0;
        p1_cyc = 0; p1_stb = 0; p1_we = 0; p1_adr = '0; p1_dat_ms = '0; p1_sel = '0; p1_cti = '0; p1_bte = '0;
        m_ack = 0; m_err = 0; m_dat_sm = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        NRST = 0;
        p0_cyc = 1; m_ack = 1; m_err = 1;
        model_reset();
        repeat (3) @(negedge CLK);
        checks++; if (GRANT !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", GRANT); end
        checks++; if (m_cyc !== 1'b0) begin failures++; $display("FAIL reset_mcyc got=%b exp=0", m_cyc); end
        checks++; if (p0_ack !== 1'b0 || p1_ack !== 1'b0 || p0_err !== 1'b0 || p1_err !== 1'b0) begin
            failures++; $display("FAIL reset_acks got=%b%b%b%b exp=0000", p0_ack, p1_ack, p0_err, p1_err); end
        @(posedge CLK); #1;
        NRST = 1; p0_cyc = 0; m_ack = 0; m_err = 0;
        @(negedge CLK);
        checks++; if (GRANT !== 2'b00 || m_cyc !== 1'b0) begin failures++; $display("FAIL idle_after_reset grant=%b cyc=%b exp=00/0", GRANT, m_cyc); end
        tick();
        @(negedge CLK);
        checks++; if (GRANT !== 2'b00 || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
            failures++; $display("FAIL idle_stay grant=%b acks=%b%b exp=00/00", GRANT, p0_ack, p1_ack); end
        tick();
    endtask

    task automatic test_single();
        p1_cyc = 1; p1_stb = 1; p1_we = 1; p1_adr = $urandom; p1_dat_ms = $urandom; p1_sel = 4'hf;
        @(negedge CLK);
        checks++; if (GRANT !== 2'b00 || m_cyc !== 1'b0) begin failures++; $display("FAIL single_latency grant=%b cyc=%b exp=00/0", GRANT, m_cyc); end
        tick();
        for (int beat = 1; beat <= 3; beat++) begin
            m_ack = (beat == 3);
            m_dat_sm = $urandom;
            @(negedge CLK);
            checks++; if (GRANT !== 2'b10) begin failures++; $display("FAIL single_grant beat=%0d got=%b exp=10", beat, GRANT); end
            checks++; if (m_adr !== p1_adr || m_dat_ms !== p1_dat_ms || m_we !== 1'b1) begin
                failures++; $display("FAIL single_route adr=%h exp=%h dat=%h exp=%h", m_adr, p1_adr, m_dat_ms, p1_dat_ms); end
            checks++; if (p1_ack !== (beat == 3) || p0_ack !== 1'b0) begin
                failures++; $display("FAIL single_ack beat=%0d ack1=%b ack0=%b exp=%b/0", beat, p1_ack, p0_ack, beat == 3); end
            tick();
        end
        p1_cyc = 0; p1_stb = 0; m_ack = 0;
        @(negedge CLK);
        checks++; if (m_cyc !== 1'b0) begin failures++; $display("FAIL single_release cyc=%b exp=0", m_cyc); end
        tick();
        @(negedge CLK);
        checks++; if (GRANT !== 2'b00) begin failures++; $display("FAIL single_idle grant=%b exp=00", GRANT); end
        tick();
    endtask

    task automatic test_tie();
        NRST = 0; model_reset();
        @(posedge CLK); #1;
        NRST = 1;
        p0_cyc = 1; p0_stb = 1; p0_adr = 32'h0000_1000;
        p1_cyc = 1; p1_stb = 1; p1_adr = 32'h0000_2000;
        tick();
        @(negedge CLK);
        checks++; if (GRANT !== 2'b01 || m_adr !== p0_adr) begin failures++; $display("FAIL tie_first grant=%b adr=%h exp=01/%h", GRANT, m_adr, p0_adr); end
        tick();
        p0_cyc = 0; p0_stb = 0;
        @(negedge CLK);
        checks++; if (m_cyc !== 1'b0 || GRANT !== 2'b01) begin failures++; $display("FAIL tie_gap cyc=%b grant=%b exp=0/01", m_cyc, GRANT); end
        tick();
        @(negedge CLK);
        checks++; if (GRANT !== 2'b10 || m_cyc !== 1'b1 || m_adr !== p1_adr) begin
            failures++; $display("FAIL tie_handover grant=%b cyc=%b adr=%h exp=10/1/%h", GRANT, m_cyc, m_adr, p1_adr); end
        tick();
        p1_cyc = 0; p1_stb = 0;
        tick();
    endtask

    task automatic test_burst();
        int acks = 0;
        p0_cyc = 1; p0_stb = 1; p0_cti = 3'b010;
        tick();
        for (int beat = 0; beat < 16; beat++) begin
            if (beat == 2) begin p1_cyc = 1; p1_stb = 1; end
            m_ack = 1; m_dat_sm = $urandom;
            @(negedge CLK);
            checks++; if (GRANT !== 2'b01) begin failures++; $display("FAIL burst_grant beat=%0d got=%b exp=01", beat, GRANT); end
            checks++; if (p1_ack !== 1'b0 || p1_dat_sm !== '0) begin
                failures++; $display("FAIL burst_isolation beat=%0d ack1=%b dat1=%h exp=0/0", beat, p1_ack, p1_dat_sm); end
            if (p0_ack === 1'b1 && p0_dat_sm === m_dat_sm) acks++;
            tick();
        end
        checks++; if (acks != 16) begin failures++; $display("FAIL burst_acks got=%0d exp=16", acks); end
        p0_cyc = 0; p0_stb = 0; p0_cti = '0; m_ack = 0;
        tick();
        @(negedge CLK);
        checks++; if (GRANT !== 2'b10) begin failures++; $display("FAIL burst_handover got=%b exp=10", GRANT); end
        p1_cyc = 0; p1_stb = 0;
        tick();
        tick();
    endtask

    task automatic test_saturation();
        logic       cycv[2];
        logic       gap[2];
        int         beats[2];
        logic [1:0] prev_g = 2'b00;
        logic [1:0] served = 2'b00;
        int         grants = 0;
        for (int i = 0; i < 2; i++) begin cycv[i] = 1; gap[i] = 0; beats[i] = 0; end
        p0_cyc = 1; p0_stb = 1; p1_cyc = 1; p1_stb = 1;
        for (int cyc_n = 0; cyc_n < 100; cyc_n++) begin
            m_ack = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            checks++; if (GRANT !== exp_grant()) begin failures++; $display("FAIL sat_grant cycle=%0d got=%b exp=%b", cyc_n, GRANT, exp_grant()); end
            if (GRANT != 2'b00 && GRANT != prev_g) begin
                checks++; if (GRANT === served) begin failures++; $display("FAIL sat_alternate cycle=%0d got=%b previous=%b", cyc_n, GRANT, served); end
                served = GRANT;
                grants++;
            end
            prev_g = GRANT;
            if (p0_ack && p0_cyc) beats[0]++;
            if (p1_ack && p1_cyc) beats[1]++;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (gap[i]) begin cycv[i] = 1; gap[i] = 0; beats[i] = 0; end
                else if (beats[i] >= 4) begin cycv[i] = 0; gap[i] = 1; end
            end
            p0_cyc = cycv[0]; p0_stb = cycv[0];
            p1_cyc = cycv[1]; p1_stb = cycv[1];
        end
        checks++; if (grants < 8) begin failures++; $display("FAIL sat_progress grants=%0d exp>=8", grants); end
        p0_cyc = 0; p0_stb = 0; p1_cyc = 0; p1_stb = 0; m_ack = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        p1_cyc = 1; p1_stb = 1; p1_adr = $urandom;
        tick();
        for (int beat = 1; beat <= 2; beat++) begin
            m_ack = 1;
            @(negedge CLK);
            tick();
        end
        m_ack = 1;
        @(negedge CLK);
        checks++; if (p1_ack !== 1'b1) begin failures++; $display("FAIL midrst_beat3 ack1=%b exp=1", p1_ack); end
        #1 NRST = 0;
        model_reset();
        #1;
        checks++; if (m_cyc !== 1'b0 || GRANT !== 2'b00) begin failures++; $display("FAIL midrst_async cyc=%b grant=%b exp=0/00", m_cyc, GRANT); end
        checks++; if (p1_ack !== 1'b0) begin failures++; $display("FAIL midrst_ack ack1=%b exp=0", p1_ack); end
        @(posedge CLK); #1;
        NRST = 1; m_ack = 0;
        p0_cyc = 1; p0_stb = 1;
        tick();
        @(negedge CLK);
        checks++; if (GRANT !== 2'b01) begin failures++; $display("FAIL midrst_tie got=%b exp=01", GRANT); end
        p0_cyc = 0; p0_stb = 0; p1_cyc = 0; p1_stb = 0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic             ec, es, ea0, ea1, ee0;
        logic [ADR_W-1:0] ea;
        logic [DAT_W-1:0] ed0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) p0_cyc = ~p0_cyc;
            if ($urandom_range(0, 3) == 0) p1_cyc = ~p1_cyc;
            p0_stb = p0_cyc & 1'($urandom); p1_stb = p1_cyc & 1'($urandom);
            p0_adr = $urandom; p1_adr = $urandom;
            m_ack = 1'($urandom); m_err = ($urandom_range(0, 7) == 0); m_dat_sm = $urandom;
            @(negedge CLK);
            ec  = (m_owner == 0) ? p0_cyc : (m_owner == 1) ? p1_cyc : 1'b0;
            es  = (m_owner == 0) ? p0_stb : (m_owner == 1) ? p1_stb : 1'b0;
            ea  = (m_owner == 0) ? p0_adr : p1_adr;
            ea0 = (m_owner == 0) & m_ack;
            ea1 = (m_owner == 1) & m_ack;
            ee0 = (m_owner == 0) & m_err;
            ed0 = (m_owner == 0) ? m_dat_sm : '0;
            checks++; if (GRANT !== exp_grant()) begin failures++; $display("FAIL rand_grant n=%0d got=%b exp=%b", n, GRANT, exp_grant()); end
            checks++; if (m_cyc !== ec || m_stb !== es) begin failures++; $display("FAIL rand_cycstb n=%0d got=%b%b exp=%b%b", n, m_cyc, m_stb, ec, es); end
            if (m_owner >= 0) begin
                checks++; if (m_adr !== ea) begin failures++; $display("FAIL rand_adr n=%0d got=%h exp=%h", n, m_adr, ea); end
            end
            checks++; if (p0_ack !== ea0 || p1_ack !== ea1 || p0_err !== ee0) begin
                failures++; $display("FAIL rand_resp n=%0d ack0=%b ack1=%b err0=%b exp=%b%b%b", n, p0_ack, p1_ack, p0_err, ea0, ea1, ee0); end
            checks++; if (p0_dat_sm !== ed0) begin failures++; $display("FAIL rand_dat0 n=%0d got=%h exp=%h", n, p0_dat_sm, ed0); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_burst();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
